// File: rtl/muldiv_ctrl.sv
// Sequencer for the EX-stage multiply/divide path: issues one op at a time, owns the
// shared adder while the op is busy, stalls stage 1 until writeback, aborts on kill/timeout.
module muldiv_ctrl #(
    parameter  int MAX_CYCLES = 40,
    localparam int CNT_W      = $clog2(MAX_CYCLES)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic [2:0] funct3_i,
    input  logic       kill_i,
    input  logic       hold_i,
    input  logic       mul_finish_i,
    input  logic       div_finish_i,
    output logic       mulit_en_o,
    output logic       div_en_o,
    output logic [1:0] alu_owner_o,
    output logic       stall_o,
    output logic       wb_en_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mul_en_reg, mul_en_next;
    logic             div_en_reg, div_en_next;
    logic             timeout_reg, timeout_next;

    // Only funct3[2] selects the family; the low bits pick the op inside the datapath.
    logic unused_funct3;
    assign unused_funct3 = ^funct3_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            mul_en_reg  <= 1'b0;
            div_en_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mul_en_reg  <= mul_en_next;
            div_en_reg  <= div_en_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mul_en_next  = mul_en_reg;
        div_en_next  = div_en_reg;
        timeout_next = 1'b0;
        alu_owner_o  = 2'd0;
        stall_o      = 1'b0;
        wb_en_o      = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (req_valid_i && !kill_i) begin
                    stall_o = 1'b1;
                    if (funct3_i[2]) begin
                        state_next  = DIV;
                        div_en_next = 1'b1;
                    end else begin
                        state_next  = MUL;
                        mul_en_next = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                alu_owner_o = (state_reg == MUL) ? 2'd1 : 2'd2;
                stall_o     = 1'b1;
                if (kill_i) begin
                    state_next  = IDLE;
                    mul_en_next = 1'b0;
                    div_en_next = 1'b0;
                end else if ((state_reg == MUL) ? mul_finish_i : div_finish_i) begin
                    // Enable stays high through WB so the result mux does not move.
                    state_next = WB;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = IDLE;
                    mul_en_next  = 1'b0;
                    div_en_next  = 1'b0;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WB: begin
                if (kill_i) begin
                    state_next  = IDLE;
                    mul_en_next = 1'b0;
                    div_en_next = 1'b0;
                end else if (hold_i) begin
                    stall_o = 1'b1;
                end else begin
                    wb_en_o     = 1'b1;
                    state_next  = IDLE;
                    mul_en_next = 1'b0;
                    div_en_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mulit_en_o = mul_en_reg;
    assign div_en_o   = div_en_reg;
    assign timeout_o  = timeout_reg;
    assign busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: each cycle's expected output vector is queued by the
// stimulus and checked by a separate monitor on the falling edge.
module tb_muldiv_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] funct3;
    logic       kill;
    logic       hold;
    logic       mul_finish;
    logic       div_finish;
    logic       mulit_en;
    logic       div_en;
    logic [1:0] alu_owner;
    logic       stall;
    logic       wb_en;
    logic       busy;
    logic       timeout;

    muldiv_ctrl #(.MAX_CYCLES(40)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .funct3_i     (funct3),
        .kill_i       (kill),
        .hold_i       (hold),
        .mul_finish_i (mul_finish),
        .div_finish_i (div_finish),
        .mulit_en_o   (mulit_en),
        .div_en_o     (div_en),
        .alu_owner_o  (alu_owner),
        .stall_o      (stall),
        .wb_en_o      (wb_en),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_item;
    logic [7:0] mon_act;
    int n_cmp = 0;
    int n_err = 0;

    // Vector layout: {mulit_en, div_en, alu_owner[1:0], stall, wb_en, busy, timeout}
    function automatic logic [7:0] e(input bit m, input bit d, input logic [1:0] own,
                                     input bit st, input bit wb, input bit bz, input bit to);
        return {m, d, own, st, wb, bz, to};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_item = sb.pop_front();
            mon_act  = {mulit_en, div_en, alu_owner, stall, wb_en, busy, timeout};
            n_cmp++;
            if (mon_act !== mon_item.exp) begin
                n_err++;
                $display("FAIL %s: got {mul,div,own,stall,wb,busy,to}=%b required %b",
                         mon_item.name, mon_act, mon_item.exp);
            end
        end
    end

    // Called at posedge+1: drive this cycle's inputs, queue the expectation, advance.
    task automatic step(input string nm, input logic rq, input logic [2:0] f3,
                        input logic k, input logic h, input logic mf, input logic df,
                        input logic [7:0] ex);
        exp_t t;
        req_valid  = rq;
        funct3     = f3;
        kill       = k;
        hold       = h;
        mul_finish = mf;
        div_finish = df;
        t.name = nm;
        t.exp  = ex;
        sb.push_back(t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 0; funct3 = 0; kill = 0; hold = 0; mul_finish = 0; div_finish = 0;
        @(posedge clk);
        #1;

        // Reset: outputs idle, stall follows req & ~kill.
        step("rst idle",       0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        step("rst stall req",  1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("rst stall kill", 1, 3'b000, 1, 0, 0, 0, e(0,0,0,0,0,0,0));
        req_valid = 0; kill = 0;
        rst_n = 1'b1;
        $display("op reset checked");

        // 1: MUL, finish in cycle 3; div_finish in MUL is ignored.
        step("t1 c0 accept", 1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("t1 c1 busy",   1, 3'b000, 0, 0, 0, 0, e(1,0,1,1,0,1,0));
        step("t1 c2 busy",   1, 3'b000, 0, 0, 0, 1, e(1,0,1,1,0,1,0));
        step("t1 c3 finish", 1, 3'b000, 0, 0, 1, 0, e(1,0,1,1,0,1,0));
        step("t1 c4 wb",     1, 3'b000, 0, 0, 0, 0, e(1,0,0,0,1,1,0));
        step("t1 c5 idle",   0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t1 MUL finish issued");

        // 2: DIV, finish in cycle 34, hold 35-36, write in 37; mul_finish in DIV ignored.
        step("t2 c0 accept", 1, 3'b100, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        for (int i = 1; i <= 33; i++)
            step($sformatf("t2 c%0d busy", i), 1, 3'b100, 0, 0, (i == 10), 0, e(0,1,2'd2,1,0,1,0));
        step("t2 c34 finish", 1, 3'b100, 0, 0, 0, 1, e(0,1,2'd2,1,0,1,0));
        step("t2 c35 hold",   1, 3'b100, 0, 1, 0, 0, e(0,1,0,1,0,1,0));
        step("t2 c36 hold",   1, 3'b100, 0, 1, 0, 0, e(0,1,0,1,0,1,0));
        step("t2 c37 wb",     1, 3'b100, 0, 0, 0, 0, e(0,1,0,0,1,1,0));
        step("t2 c38 idle",   0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t2 DIV with hold issued");

        // 3: kill beats div_finish in cycle 5.
        step("t3 c0 accept", 1, 3'b101, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        for (int i = 1; i <= 4; i++)
            step($sformatf("t3 c%0d busy", i), 1, 3'b101, 0, 0, 0, 0, e(0,1,2'd2,1,0,1,0));
        step("t3 c5 kill+fin", 1, 3'b101, 1, 0, 0, 1, e(0,1,2'd2,1,0,1,0));
        step("t3 c6 idle",     0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        step("t3 c7 idle",     0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t3 DIV killed issued");

        // 4: MUL never finishes -> timeout pulse in cycle 41.
        step("t4 c0 accept", 1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        for (int i = 1; i <= 40; i++)
            step($sformatf("t4 c%0d busy", i), 1, 3'b000, 0, 0, 0, 0, e(1,0,2'd1,1,0,1,0));
        step("t4 c41 timeout", 0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,1));
        step("t4 c42 clear",   0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t4 MUL timeout issued");

        // 5: two MULs back-to-back, writes in cycles 2 and 5.
        step("t5 c0 accept", 1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("t5 c1 finish", 1, 3'b000, 0, 0, 1, 0, e(1,0,2'd1,1,0,1,0));
        step("t5 c2 wb",     1, 3'b000, 0, 0, 0, 0, e(1,0,0,0,1,1,0));
        step("t5 c3 accept", 1, 3'b001, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("t5 c4 finish", 1, 3'b001, 0, 0, 1, 0, e(1,0,2'd1,1,0,1,0));
        step("t5 c5 wb",     1, 3'b001, 0, 0, 0, 0, e(1,0,0,0,1,1,0));
        step("t5 c6 idle",   0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t5 back-to-back MUL issued");

        // 6: async reset mid-MUL, then re-accept on the first edge after release.
        step("t6 c0 accept", 1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("t6 c1 busy",   1, 3'b000, 0, 0, 0, 0, e(1,0,2'd1,1,0,1,0));
        rst_n = 1'b0;
        step("t6 c2 in reset", 1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        rst_n = 1'b1;
        step("t6 c3 accept", 1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("t6 c4 finish", 1, 3'b000, 0, 0, 1, 0, e(1,0,2'd1,1,0,1,0));
        step("t6 c5 wb",     1, 3'b000, 0, 0, 0, 0, e(1,0,0,0,1,1,0));
        step("t6 c6 idle",   0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t6 reset mid-op issued");

        // 7: killed request in IDLE is not accepted.
        step("t7 c0 kill req", 1, 3'b100, 1, 0, 0, 0, e(0,0,0,0,0,0,0));
        step("t7 c1 idle",     0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t7 kill in IDLE issued");

        // 8: kill during a held writeback suppresses the write.
        step("t8 c0 accept",  1, 3'b000, 0, 0, 0, 0, e(0,0,0,1,0,0,0));
        step("t8 c1 finish",  1, 3'b000, 0, 0, 1, 0, e(1,0,2'd1,1,0,1,0));
        step("t8 c2 hold",    1, 3'b000, 0, 1, 0, 0, e(1,0,0,1,0,1,0));
        step("t8 c3 kill wb", 1, 3'b000, 1, 1, 0, 0, e(1,0,0,0,0,1,0));
        step("t8 c4 idle",    0, 3'b000, 0, 0, 0, 0, e(0,0,0,0,0,0,0));
        $display("op t8 kill in WB issued");

        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
